pipeline_hazard_ctrl: RTL and testbench

Central sequencer for the 5-stage pipeline latch bank (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates the latch controls ppEN, bubble and ifidKill.
- Generates the PC write enable and the gated i/d-cache requests.
- Inputs: cache hit handshakes, load-use hazard detection, decode-stage branch redirect, halt retirement.
- Sits between the caches, the control unit, the PC and the pipeline latch bank, one instance per core.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 13 +
 rtl/pipeline_hazard_detect.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: register index type and run/halt state.
package pipeline_hazard_ctrl_pkg;

   localparam int unsigned REGW_DEF = 5;

   typedef logic [REGW_DEF-1:0] regbits_t;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } haz_state_t;

endpackage

// File: rtl/pipeline_hazard_detect.sv
// Load-use hazard detection between ID/EX and IF/ID; purely combinational so the
// forwarding unit can reuse it.
module hazard_detect #(
   parameter int unsigned REGW = 5
) (
   input  logic            dmem_ren_idex_i,
   input  logic            rwen_idex_i,
   input  logic [REGW-1:0] wsel_idex_i,
   input  logic [REGW-1:0] rs_ifid_i,
   input  logic [REGW-1:0] rt_ifid_i,
   input  logic            rt_used_ifid_i,
   output logic            lu_o
);

   logic wsel_nz_s;
   logic rs_match_s;
   logic rt_match_s;

   // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign wsel_nz_s  = (wsel_idex_i != {REGW{1'b0}});
   assign rs_match_s = (wsel_idex_i == rs_ifid_i);
   assign rt_match_s = rt_used_ifid_i & (wsel_idex_i == rt_ifid_i);
   assign lu_o       = dmem_ren_idex_i & rwen_idex_i & wsel_nz_s & (rs_match_s | rt_match_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central latch-bank sequencer: ppEN/bubble/ifidKill, PC write and gated cache requests.
// Optional stall/bubble counters are built when PIPELINE_HAZARD_CTRL_STALL_CNT_EN is defined.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REGW  = 5,
   parameter int unsigned CNT_W = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            ihit,
   input  logic            dhit,
   input  logic            cu_dmemREN_EXME,
   input  logic            cu_dmemWEN_EXME,
   input  logic            cu_dmemREN_IDEX,
   input  logic            cu_rWEN_IDEX,
   input  logic [REGW-1:0] wsel_IDEX,
   input  logic [REGW-1:0] rs_IFID,
   input  logic [REGW-1:0] rt_IFID,
   input  logic            rt_used_IFID,
   input  logic            redirect,
   input  logic            halt_MEWB,
   output logic            ppEN,
   output logic            bubble,
   output logic            ifidKill,
   output logic            pcWEN,
   output logic            imemREN,
   output logic            dmemREN,
   output logic            dmemWEN,
   output logic            halt
`ifdef PIPELINE_HAZARD_CTRL_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
`endif
);

   if (CNT_W < 2) begin : g_cnt_w_chk
      $error("CNT_W must be at least 2");
   end

   haz_state_t state_q;
   logic       dmem_done_q;
   logic       dmem_done_d;
   logic       run_s;
   logic       mem_op_s;
   logic       mem_ok_s;
   logic       lu_s;

   hazard_detect #(.REGW(REGW)) u_hazard_detect (
      .dmem_ren_idex_i (cu_dmemREN_IDEX),
      .rwen_idex_i     (cu_rWEN_IDEX),
      .wsel_idex_i     (wsel_IDEX),
      .rs_ifid_i       (rs_IFID),
      .rt_ifid_i       (rt_IFID),
      .rt_used_ifid_i  (rt_used_IFID),
      .lu_o            (lu_s)
   );

   assign run_s    = (state_q == RUN);
   assign mem_op_s = cu_dmemREN_EXME | cu_dmemWEN_EXME;
   assign mem_ok_s = ~mem_op_s | dhit | dmem_done_q;

   // Load-use beats redirect: the branch operand is not yet valid.
   assign ppEN     = run_s & ihit & mem_ok_s;
   assign bubble   = run_s & lu_s;
   assign ifidKill = run_s & redirect & ~lu_s;
   assign pcWEN    = ppEN & ~bubble;
   assign imemREN  = run_s;
   assign dmemREN  = run_s & cu_dmemREN_EXME & ~dmem_done_q;
   assign dmemWEN  = run_s & cu_dmemWEN_EXME & ~dmem_done_q;
   assign halt     = (state_q == HALT);

   // A data access finished while the i-side still misses must not be reissued.
   always_comb begin
      dmem_done_d = dmem_done_q;
      if (ppEN) begin
         dmem_done_d = 1'b0;
      end else if (run_s & mem_op_s & dhit) begin
         dmem_done_d = 1'b1;
      end else begin
         dmem_done_d = dmem_done_q;
      end
   end

   // Run/halt state machine plus the completed-access flag.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= RUN;
         dmem_done_q <= 1'b0;
      end else begin
         dmem_done_q <= dmem_done_d;
         case (state_q)
            RUN:     if (ppEN & halt_MEWB) state_q <= HALT;
            HALT:    state_q <= HALT;
            default: state_q <= RUN;
         endcase
      end
   end

`ifdef PIPELINE_HAZARD_CTRL_STALL_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] bubble_cnt_q;

   // Saturating performance counters, frozen once halted.
   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cnt_q  <= {CNT_W{1'b0}};
         bubble_cnt_q <= {CNT_W{1'b0}};
      end else begin
         if (run_s & ~ppEN & (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
         end
         if (ppEN & bubble & (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
         end
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for pipeline_hazard_ctrl against a behavioural model.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned REGW = 5;
`ifdef PIPELINE_HAZARD_CTRL_STALL_CNT_EN
   localparam int unsigned TB_CNT_W = 3;
`else
   localparam int unsigned TB_CNT_W = 32;
`endif

   logic CLK = 1'b0;
   logic RST, ihit, dhit, ren_ex, wen_ex, ren_idex, rwen_idex, rt_used, redirect, halt_mewb;
   logic [REGW-1:0] wsel, rs, rt;
   logic ppEN, bubble, ifidKill, pcWEN, imemREN, dmemREN, dmemWEN, halt;
`ifdef PIPELINE_HAZARD_CTRL_STALL_CNT_EN
   logic [TB_CNT_W-1:0] stall_cnt, bubble_cnt;
`endif

   int vec_cnt = 0;
   int miscmp_cnt = 0;

   // Reference model state: halted flag, completed-access flag, counters
   bit m_halted = 1'b0;
   bit m_done = 1'b0;
   int m_stall = 0;
   int m_bub = 0;
   int halted_cycles = 0;

   always #5 CLK = ~CLK;

   pipeline_hazard_ctrl #(.REGW(REGW), .CNT_W(TB_CNT_W)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
      .cu_dmemREN_EXME(ren_ex), .cu_dmemWEN_EXME(wen_ex),
      .cu_dmemREN_IDEX(ren_idex), .cu_rWEN_IDEX(rwen_idex),
      .wsel_IDEX(wsel), .rs_IFID(rs), .rt_IFID(rt), .rt_used_IFID(rt_used),
      .redirect(redirect), .halt_MEWB(halt_mewb),
      .ppEN(ppEN), .bubble(bubble), .ifidKill(ifidKill), .pcWEN(pcWEN),
      .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .halt(halt)
`ifdef PIPELINE_HAZARD_CTRL_STALL_CNT_EN
      , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         miscmp_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      RST = 1'b0; ihit = 1'b0; dhit = 1'b0; ren_ex = 1'b0; wen_ex = 1'b0;
      ren_idex = 1'b0; rwen_idex = 1'b0; rt_used = 1'b0; redirect = 1'b0;
      halt_mewb = 1'b0; wsel = '0; rs = '0; rt = '0;
   endtask

   function automatic bit model_lu();
      bit dep;
      dep = (wsel == rs) || (rt_used && (wsel == rt));
      return ren_idex && rwen_idex && (wsel != 0) && dep;
   endfunction

   // Check all outputs this cycle, then advance the model across the next edge
   task automatic step();
      bit lu, access_needed, access_satisfied, adv, e_bub, e_kill;
      @(negedge CLK);
      lu = model_lu();
      access_needed = ren_ex || wen_ex;
      access_satisfied = !access_needed || dhit || m_done;
      adv = !m_halted && ihit && access_satisfied;
      e_bub = !m_halted && lu;
      e_kill = !m_halted && redirect && !lu;
      chk("ppEN", 64'(ppEN), 64'(adv));
      chk("bubble", 64'(bubble), 64'(e_bub));
      chk("ifidKill", 64'(ifidKill), 64'(e_kill));
      chk("pcWEN", 64'(pcWEN), 64'(adv && !e_bub));
      chk("imemREN", 64'(imemREN), 64'(!m_halted));
      chk("dmemREN", 64'(dmemREN), 64'(!m_halted && ren_ex && !m_done));
      chk("dmemWEN", 64'(dmemWEN), 64'(!m_halted && wen_ex && !m_done));
      chk("halt", 64'(halt), 64'(m_halted));
`ifdef PIPELINE_HAZARD_CTRL_STALL_CNT_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
`endif
      if (RST) begin
         m_halted = 1'b0; m_done = 1'b0; m_stall = 0; m_bub = 0;
      end else begin
         if (!m_halted) begin
            if (!adv && m_stall < (2 ** TB_CNT_W) - 1) m_stall++;
            if (adv && e_bub && m_bub < (2 ** TB_CNT_W) - 1) m_bub++;
         end
         if (adv) m_done = 1'b0;
         else if (!m_halted && access_needed && dhit) m_done = 1'b1;
         if (!m_halted && adv && halt_mewb) m_halted = 1'b1;
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      clr_in();
      RST = 1'b1;
      @(posedge CLK);
      #1;
      // Reset held two cycles, one idle miss cycle, then free-running hits
      step(); step();
      RST = 1'b0;
      step();
      ihit = 1'b1;
      repeat (4) step();

      // Load-use on rs, then the same with the zero register
      ren_idex = 1'b1; rwen_idex = 1'b1; wsel = 5'd5; rs = 5'd5;
      step();
      wsel = 5'd0; rs = 5'd0;
      step();
      ren_idex = 1'b0; rwen_idex = 1'b0;
      step();

      // Store completes at cycle 3 while the i-side misses until cycle 6
      wen_ex = 1'b1; ihit = 1'b0;
      for (int c = 0; c <= 6; c++) begin
         dhit = (c == 3);
         ihit = (c == 6);
         step();
      end
      wen_ex = 1'b0; dhit = 1'b0;
      step();

      // Redirect alone, then redirect under a load-use on rt
      redirect = 1'b1;
      step();
      ren_idex = 1'b1; rwen_idex = 1'b1; wsel = 5'd7; rt = 5'd7; rs = 5'd2; rt_used = 1'b1;
      step();
      clr_in(); ihit = 1'b1;
      step();

      // Halt in MEM/WB held off by two dcache miss cycles
      halt_mewb = 1'b1; ren_ex = 1'b1; dhit = 1'b0;
      step(); step();
      dhit = 1'b1;
      step();
      repeat (3) step();
      clr_in(); ihit = 1'b1; ren_ex = 1'b1; dhit = 1'b1;
      step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      step();

      // Randomized traffic with occasional resets and halts
      for (int n = 0; n < 400; n++) begin
         ihit      = ($urandom_range(0, 3) != 0);
         dhit      = ($urandom_range(0, 2) == 0);
         ren_ex    = ($urandom_range(0, 2) == 0);
         wen_ex    = !ren_ex && ($urandom_range(0, 3) == 0);
         ren_idex  = $urandom_range(0, 1);
         rwen_idex = ($urandom_range(0, 3) != 0);
         wsel      = REGW'($urandom_range(0, 3));
         rs        = REGW'($urandom_range(0, 3));
         rt        = REGW'($urandom_range(0, 3));
         rt_used   = $urandom_range(0, 1);
         redirect  = ($urandom_range(0, 3) == 0);
         halt_mewb = ($urandom_range(0, 39) == 0);
         halted_cycles = m_halted ? halted_cycles + 1 : 0;
         RST       = ($urandom_range(0, 59) == 0) || (halted_cycles > 4);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
      $finish;
   end

endmodule
